// File: rtl/mem_pkg.sv
// Shared types for the SRAM-like handshake block: bus size encoding, the
// held-request record, the per-transaction tag, the FSM state type and
// the kseg0/kseg1 address translation helper.
package mem_pkg;

  // Field widths of the held-request record; the top's ADDR_W/DATA_W must
  // not exceed these.
  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    MSIZE_BYTE = 2'd0,
    MSIZE_HALF = 2'd1,
    MSIZE_WORD = 2'd2,
    MSIZE_RSVD = 2'd3
  } msize_t;

  typedef struct packed {
    logic                  wr;
    msize_t                size;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } sramx_req_t;

  typedef struct packed {
    logic drop;
  } sramx_tag_t;

  typedef enum logic {
    HS_IDLE      = 1'b0,
    HS_WAIT_ADDR = 1'b1
  } hs_state_t;

  // Map the unmapped kernel segments onto the low physical window:
  // 0x8/0xA -> 0x0 and 0x9/0xB -> 0x1 in the top nibble.
  function automatic logic [31:0] sramx_xlate(input logic [31:0] vaddr);
    logic [31:0] paddr;
    paddr = vaddr;
    case (vaddr[31:28])
      4'h8, 4'hA: paddr = {4'h0, vaddr[27:0]};
      4'h9, 4'hB: paddr = {4'h1, vaddr[27:0]};
      default:    paddr = vaddr;
    endcase
    return paddr;
  endfunction

endpackage

// File: rtl/sramx_tag_fifo.sv
// Tag FIFO for the SRAM-like handshake: one entry per bus transaction whose
// address was accepted but whose response has not returned yet. Every entry
// carries a drop flag that a flush can set on all stored entries at once.
module sramx_tag_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  sramx_tag_t       push_tag_i,
  input  logic             pop_i,
  input  logic             mark_all_drop_i,
  output sramx_tag_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [DEPTH-1:0] drop_q, drop_d;
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = '{drop: drop_q[rd_ptr_q]};

  // A pop on an empty FIFO is a bus protocol error and is ignored.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & ~full_o;

  // Flush marks every slot first; a push in the same cycle then writes its
  // own flag (the caller already folds the flush into it).
  always_comb begin
    drop_d = drop_q;
    if (mark_all_drop_i) drop_d = '1;
    if (do_push) drop_d[wr_ptr_q] = push_tag_i.drop;
  end

  // Pointer, occupancy and flag storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      drop_q <= drop_d;
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sramx_handshake.sv
// SRAM-like bus handshake with up to MAX_OUTSTANDING transactions in flight.
// A CPU request is issued combinationally when the bus accepts it at once;
// otherwise it is parked in a hold register and req stays high with stable
// fields until addr_ok. Flush marks every in-flight transaction as dropped so
// its response is consumed from the bus without being reported to the CPU.
// Optional macro SRAMX_ADDR_XLATE_EN: translate kseg0/kseg1 virtual addresses
// to physical before issue (ADDR_W must then be 32).
module sramx_handshake
  import mem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned PEND_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [1:0]        cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_data_ok,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  output logic [PEND_W-1:0] pending,
  output logic              req,
  output logic              wr,
  output logic [1:0]        size,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic              addr_ok,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata
);

  hs_state_t   state_q, state_d;
  sramx_req_t  hold_q, hold_d;
  logic        hold_drop_q, hold_drop_d;

  logic [ADDR_W-1:0] cpu_addr_x;
  sramx_req_t        cur_req, bus_c;
  logic              cpu_ready_c, req_c, push_c;
  sramx_tag_t        push_tag_c, head_tag;
  logic [PEND_W-1:0] fifo_count;
  logic              fifo_full, fifo_empty;

`ifdef SRAMX_ADDR_XLATE_EN
  assign cpu_addr_x = sramx_xlate(cpu_addr);
`else
  assign cpu_addr_x = cpu_addr;
`endif

  // Translation happens here, ahead of the hold register, so the held
  // address is already physical.
  assign cur_req = '{wr:    cpu_wr,
                     size:  msize_t'(cpu_size),
                     addr:  MEM_ADDR_W'(cpu_addr_x),
                     wdata: MEM_DATA_W'(cpu_wdata)};

  sramx_tag_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_i         (push_c & ~reset),
    .push_tag_i     (push_tag_c),
    .pop_i          (data_ok & ~reset),
    .mark_all_drop_i(flush & ~reset),
    .head_o         (head_tag),
    .count_o        (fifo_count),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty)
  );

  // Next-state, hold-register update and bus-side request selection.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_drop_d = hold_drop_q;
    cpu_ready_c = 1'b0;
    req_c       = 1'b0;
    bus_c       = cur_req;
    push_c      = 1'b0;
    push_tag_c  = '{drop: 1'b0};
    case (state_q)
      HS_IDLE: begin
        // Flush wins over a new request; a full tag FIFO blocks issue.
        cpu_ready_c = cpu_req & ~fifo_full & ~flush;
        req_c       = cpu_ready_c;
        if (cpu_ready_c) begin
          if (addr_ok) begin
            push_c = 1'b1;
          end else begin
            hold_d      = cur_req;
            hold_drop_d = 1'b0;
            state_d     = HS_WAIT_ADDR;
          end
        end
      end
      HS_WAIT_ADDR: begin
        // The held request must still issue after a flush; it is only
        // tagged so that its response is swallowed.
        req_c = 1'b1;
        bus_c = hold_q;
        if (flush) hold_drop_d = 1'b1;
        if (addr_ok) begin
          push_c          = 1'b1;
          push_tag_c.drop = hold_drop_q | flush;
          state_d         = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  // FSM state and hold register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HS_IDLE;
      hold_q      <= '0;
      hold_drop_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_drop_q <= hold_drop_d;
    end
  end

  // Outputs are forced low while reset is asserted so nothing leaks onto
  // the bus or back to the CPU in the reset cycle.
  always_comb begin
    cpu_ready   = 1'b0;
    cpu_data_ok = 1'b0;
    cpu_rdata   = '0;
    req         = 1'b0;
    wr          = 1'b0;
    size        = 2'd0;
    addr        = '0;
    wdata       = '0;
    if (!reset) begin
      cpu_ready   = cpu_ready_c;
      cpu_data_ok = data_ok & ~fifo_empty & ~head_tag.drop;
      cpu_rdata   = rdata;
      req         = req_c;
      wr          = bus_c.wr;
      size        = bus_c.size;
      addr        = ADDR_W'(bus_c.addr);
      wdata       = DATA_W'(bus_c.wdata);
    end
  end

  // The held request counts as in flight even before the bus takes it.
  assign pending = fifo_count + PEND_W'(state_q == HS_WAIT_ADDR);

endmodule
